// File: rtl/replacement_rank_table_pkg.sv
// rtl/replacement_rank_table_pkg.sv - shared types for the true-LRU rank table
package ReplacementTypes;

  localparam int LRU_WAY_NUM = 4;
  localparam int LRU_RANK_WIDTH = $clog2(LRU_WAY_NUM);
  localparam int LRU_INDEX_MAX_WIDTH = 16;

  typedef logic [LRU_RANK_WIDTH-1:0] LRU_Rank;
  typedef LRU_Rank [LRU_WAY_NUM-1:0] LRU_Entry;

  typedef struct packed {
    logic                           valid;
    logic [LRU_INDEX_MAX_WIDTH-1:0] index;
    LRU_Entry                       entry;
  } LRU_StageEntry;

  typedef enum logic {
    LRU_INIT,
    LRU_READY
  } LRU_State;

  // Identity permutation: way 0 is least recently used.
  function automatic LRU_Entry lru_init_entry();
    LRU_Entry e;
    for (int j = 0; j < LRU_WAY_NUM; j++) e[j] = LRU_Rank'(j);
    return e;
  endfunction

endpackage

// File: rtl/replacement_rank_table_lru_rank_update.sv
// rtl/replacement_rank_table_lru_rank_update.sv - promote one way to MRU, keeping the ranks a permutation
module lru_rank_update
  import ReplacementTypes::*;
(
  input  LRU_Entry entry_i,
  input  LRU_Rank  way_i,
  output LRU_Entry entry_o
);

  LRU_Rank old_rank;

  always_comb begin
    old_rank = entry_i[way_i];
    for (int w = 0; w < LRU_WAY_NUM; w++) begin
      if (LRU_Rank'(w) == way_i)
        entry_o[w] = LRU_Rank'(LRU_WAY_NUM - 1);
      else if (entry_i[w] > old_rank)
        entry_o[w] = entry_i[w] - LRU_Rank'(1);
      else
        entry_o[w] = entry_i[w];
    end
  end

endmodule

// File: rtl/replacement_rank_table.sv
// rtl/replacement_rank_table.sv - multi-port true-LRU table with merged, pipelined updates
// Optional RSD_LRU_LOOKUP_BYPASS_EN: lookups also forward from the pending update stage.
module replacement_rank_table
  import ReplacementTypes::*;
#(
  parameter int INDEX_BIT_WIDTH = 6,
  parameter int PORT_WIDTH      = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flushReq,
  output logic                       busy,
  input  logic [INDEX_BIT_WIDTH-1:0] lookupIndex   [PORT_WIDTH],
  input  logic [LRU_WAY_NUM-1:0]     lookupWayMask [PORT_WIDTH],
  output logic                       victimValid   [PORT_WIDTH],
  output LRU_Rank                    victimWay     [PORT_WIDTH],
  input  logic                       update        [PORT_WIDTH],
  input  logic [INDEX_BIT_WIDTH-1:0] updateIndex   [PORT_WIDTH],
  input  LRU_Rank                    updateWay     [PORT_WIDTH]
);

  localparam int ENTRY_NUM = 1 << INDEX_BIT_WIDTH;
  typedef logic [INDEX_BIT_WIDTH-1:0] index_t;

  LRU_State      state_q;
  index_t        counter_q;
  LRU_Entry      mem_q        [ENTRY_NUM];
  LRU_StageEntry stage_q      [PORT_WIDTH];
  LRU_StageEntry stage_d      [PORT_WIDTH];
  LRU_Entry      fwd_entry    [PORT_WIDTH];
  LRU_Entry      lookup_entry [PORT_WIDTH];
  logic          accept;

  function automatic LRU_Entry read_forwarded(input index_t idx);
    LRU_Entry e;
    e = mem_q[idx];
    for (int k = 0; k < PORT_WIDTH; k++)
      if (stage_q[k].valid && stage_q[k].index == LRU_INDEX_MAX_WIDTH'(idx))
        e = stage_q[k].entry;
    return e;
  endfunction

  assign busy   = (state_q == LRU_INIT);
  assign accept = (state_q == LRU_READY) && !flushReq;

  always_comb begin
    for (int p = 0; p < PORT_WIDTH; p++) begin
      fwd_entry[p] = read_forwarded(updateIndex[p]);
`ifdef RSD_LRU_LOOKUP_BYPASS_EN
      lookup_entry[p] = read_forwarded(lookupIndex[p]);
`else
      lookup_entry[p] = mem_q[lookupIndex[p]];
`endif
    end
  end

  always_comb begin
    for (int p = 0; p < PORT_WIDTH; p++) begin
      LRU_Rank best;
      logic    found;
      best           = '1;
      found          = 1'b0;
      victimWay[p]   = '0;
      for (int w = 0; w < LRU_WAY_NUM; w++) begin
        if (lookupWayMask[p][w] && (!found || lookup_entry[p][w] < best)) begin
          found        = 1'b1;
          best         = lookup_entry[p][w];
          victimWay[p] = LRU_Rank'(w);
        end
      end
      victimValid[p] = !busy && found;
      if (busy) victimWay[p] = '0;
    end
  end

  // Each port starts from the result of the nearest lower port on the same
  // index; hist carries the results of ports 0..p down the chain.
  for (genvar p = 0; p < PORT_WIDTH; p++) begin : g_port
    LRU_Entry base;
    LRU_Entry result;
    logic     last_of_group;

    if (p == 0) begin : g_base
      assign base = fwd_entry[0];
    end else begin : g_base
      always_comb begin
        base = fwd_entry[p];
        for (int q = 0; q < p; q++)
          if (update[q] && updateIndex[q] == updateIndex[p])
            base = g_port[p-1].g_hist.hist[q];
      end
    end

    if (p < PORT_WIDTH - 1) begin : g_hist
      LRU_Entry hist [PORT_WIDTH];
      if (p == 0) begin : g_h
        always_comb begin
          for (int i = 0; i < PORT_WIDTH; i++) hist[i] = '0;
          hist[0] = result;
        end
      end else begin : g_h
        always_comb begin
          hist    = g_port[p-1].g_hist.hist;
          hist[p] = result;
        end
      end
    end

    always_comb begin
      last_of_group = 1'b1;
      for (int q = p + 1; q < PORT_WIDTH; q++)
        if (update[q] && updateIndex[q] == updateIndex[p]) last_of_group = 1'b0;
    end

    lru_rank_update u_rank_update (
      .entry_i (base),
      .way_i   (updateWay[p]),
      .entry_o (result)
    );

    assign stage_d[p] = '{valid: accept && update[p] && last_of_group,
                          index: LRU_INDEX_MAX_WIDTH'(updateIndex[p]),
                          entry: result};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= LRU_INIT;
      counter_q <= '0;
      for (int k = 0; k < PORT_WIDTH; k++) stage_q[k] <= '0;
    end else begin
      for (int k = 0; k < PORT_WIDTH; k++) stage_q[k] <= stage_d[k];
      case (state_q)
        LRU_INIT: begin
          if (flushReq) begin
            counter_q <= '0;
          end else begin
            counter_q <= counter_q + index_t'(1);
            if (counter_q == index_t'(ENTRY_NUM - 1)) state_q <= LRU_READY;
          end
        end
        LRU_READY: begin
          if (flushReq) begin
            state_q   <= LRU_INIT;
            counter_q <= '0;
          end
        end
        default: state_q <= LRU_INIT;
      endcase
    end
  end

  // The array has no reset; the INIT sweep is what makes it valid.
  always_ff @(posedge clk) begin
    if (state_q == LRU_INIT) begin
      mem_q[counter_q] <= lru_init_entry();
    end else if (!flushReq) begin
      for (int k = 0; k < PORT_WIDTH; k++)
        if (stage_q[k].valid) mem_q[index_t'(stage_q[k].index)] <= stage_q[k].entry;
    end
  end

endmodule

// File: tb/tb_replacement_rank_table.sv
// tb/tb_replacement_rank_table.sv - randomized bench for replacement_rank_table against an LRU-order model
module tb_replacement_rank_table;

  localparam int IW = 2;
  localparam int PW = 2;
  localparam int WN = 4;
  localparam int EN = 4;
`ifdef RSD_LRU_LOOKUP_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flushReq;
  logic          busy;
  logic [IW-1:0] lookupIndex   [PW];
  logic [WN-1:0] lookupWayMask [PW];
  logic          victimValid   [PW];
  logic [1:0]    victimWay     [PW];
  logic          update        [PW];
  logic [IW-1:0] updateIndex   [PW];
  logic [1:0]    updateWay     [PW];

  replacement_rank_table #(.INDEX_BIT_WIDTH(IW), .PORT_WIDTH(PW)) dut (
    .clk           (clk),
    .rst           (rst),
    .flushReq      (flushReq),
    .busy          (busy),
    .lookupIndex   (lookupIndex),
    .lookupWayMask (lookupWayMask),
    .victimValid   (victimValid),
    .victimWay     (victimWay),
    .update        (update),
    .updateIndex   (updateIndex),
    .updateWay     (updateWay)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Model: per set, ways listed from least to most recently used.
  int ord  [EN][WN];
  int ordp [EN][WN];
  int busy_left = EN;

  task automatic model_init();
    for (int i = 0; i < EN; i++)
      for (int j = 0; j < WN; j++) begin
        ord[i][j]  = j;
        ordp[i][j] = j;
      end
  endtask

  task automatic touch(input int idx, input int way);
    int pos;
    pos = 0;
    for (int k = 0; k < WN; k++) if (ord[idx][k] == way) pos = k;
    for (int k = pos; k < WN - 1; k++) ord[idx][k] = ord[idx][k+1];
    ord[idx][WN-1] = way;
  endtask

  function automatic int exp_victim(input int idx, input logic [WN-1:0] mask);
    int w;
    for (int k = 0; k < WN; k++) begin
      w = BYPASS ? ord[idx][k] : ordp[idx][k];
      if (mask[w]) return w;
    end
    return 0;
  endfunction

  initial begin
    model_init();
    forever begin
      @(posedge clk);
      if (!rst) begin
        busy_left = EN;
        model_init();
      end else begin
        ordp = ord;
        if (flushReq) begin
          busy_left = EN;
          model_init();
        end else if (busy_left > 0) begin
          busy_left--;
        end else begin
          for (int p = 0; p < PW; p++)
            if (update[p]) touch(int'(updateIndex[p]), int'(updateWay[p]));
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("busy", 32'(busy), 32'(busy_left > 0));
      for (int p = 0; p < PW; p++) begin
        logic ev;
        int   ew;
        ev = (busy_left == 0) && (lookupWayMask[p] != '0);
        ew = ev ? exp_victim(int'(lookupIndex[p]), lookupWayMask[p]) : 0;
        check("victimValid", 32'(victimValid[p]), 32'(ev));
        check("victimWay", 32'(victimWay[p]), 32'(ew));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flushReq = 1'b0;
    for (int p = 0; p < PW; p++) begin
      update[p] = 1'b0; updateIndex[p] = '0; updateWay[p] = '0;
      lookupIndex[p] = '0; lookupWayMask[p] = 4'b1111;
    end
  endtask

  task automatic look(input int i0, input logic [3:0] m0, input int i1, input logic [3:0] m1);
    lookupIndex[0] = IW'(i0); lookupWayMask[0] = m0;
    lookupIndex[1] = IW'(i1); lookupWayMask[1] = m1;
  endtask

  task automatic upd(input int p, input int idx, input int way);
    update[p] = 1'b1; updateIndex[p] = IW'(idx); updateWay[p] = 2'(way);
  endtask

  initial begin
    int cnt;
    idle();
    repeat (3) step();
    rst = 1'b1;

    // Reset release: four INIT cycles, then identity ranks everywhere.
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check("init_busy_cycles", 32'(cnt), 32'd4);
    for (int i = 0; i < EN; i++) begin
      step(); look(i, 4'b1111, EN - 1 - i, 4'b1111);
      @(negedge clk);
      check("init_victim", 32'(victimWay[0]), 32'd0);
      check("init_valid", 32'(victimValid[0]), 32'd1);
    end

    // Single update and lookup forwarding.
    step(); idle(); upd(0, 1, 0); look(1, 4'b1111, 1, 4'b1111);
    step(); update[0] = 1'b0;
    @(negedge clk);
    check("fwd_t1", 32'(victimWay[0]), BYPASS ? 32'd1 : 32'd0);
    step();
    @(negedge clk);
    check("fwd_t2", 32'(victimWay[0]), 32'd1);

    // Same-cycle merge on index 2: ranks [2,3,0,1].
    step(); upd(0, 2, 0); upd(1, 2, 1);
    step(); idle();
    step(); look(2, 4'b1111, 2, 4'b1011);
    @(negedge clk);
    check("merge_victim", 32'(victimWay[0]), 32'd2);
    check("mask_1011", 32'(victimWay[1]), 32'd3);
    step(); look(2, 4'b0000, 2, 4'b0011);
    @(negedge clk);
    check("mask_0000_valid", 32'(victimValid[0]), 32'd0);
    check("mask_0000_way", 32'(victimWay[0]), 32'd0);
    check("mask_0011", 32'(victimWay[1]), 32'd0);

    // Back-to-back updates on index 3 through the stage forward.
    step(); idle(); upd(0, 3, 0);
    step(); idle(); upd(1, 3, 1);
    step(); idle();
    step(); look(3, 4'b1111, 3, 4'b1011);
    @(negedge clk);
    check("b2b_victim", 32'(victimWay[0]), 32'd2);
    check("b2b_mask_1011", 32'(victimWay[1]), 32'd3);
    step(); look(3, 4'b0011, 3, 4'b0110);
    @(negedge clk);
    check("b2b_mask_0011", 32'(victimWay[0]), 32'd0);
    check("b2b_mask_0110", 32'(victimWay[1]), 32'd2);

    // Flush with a stage write pending; updates while busy are ignored.
    step(); idle(); upd(0, 0, 0);
    step(); idle(); upd(1, 1, 2); flushReq = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(); idle();
      if (i < 4) begin
        upd(0, $urandom_range(0, EN - 1), $urandom_range(0, WN - 1));
        upd(1, $urandom_range(0, EN - 1), $urandom_range(0, WN - 1));
      end
      @(negedge clk);
      if (busy) cnt++;
    end
    check("flush_busy_cycles", 32'(cnt), 32'd4);
    for (int i = 0; i < EN; i++) begin
      step(); idle(); look(i, 4'b1111, i, 4'b1110);
      @(negedge clk);
      check("flush_victim", 32'(victimWay[0]), 32'd0);
      check("flush_victim_m", 32'(victimWay[1]), 32'd1);
    end

    // Randomized traffic with occasional flushes.
    for (int n = 0; n < 600; n++) begin
      step();
      flushReq = ($urandom_range(0, 63) == 0);
      for (int p = 0; p < PW; p++) begin
        update[p]        = 1'($urandom_range(0, 1));
        updateIndex[p]   = IW'($urandom_range(0, EN - 1));
        updateWay[p]     = 2'($urandom_range(0, WN - 1));
        lookupIndex[p]   = IW'($urandom_range(0, EN - 1));
        lookupWayMask[p] = 4'($urandom_range(0, 15));
      end
    end
    step(); idle();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
